// File: rtl/wave_capture_pkg.sv
// Shared widths, FSM encodings and the sample-to-display conversion for the
// wave capture block.
package wave_capture_pkg;

    localparam int SAMPLE_W   = 16;
    localparam int OUT_W      = 8;
    localparam int FRAME_LOG2 = 8;
    localparam int ADDR_W     = FRAME_LOG2 + 1;

    typedef logic [1:0] state_t;

    localparam state_t ST_ARMED  = 2'd0;
    localparam state_t ST_ACTIVE = 2'd1;
    localparam state_t ST_WAIT   = 2'd2;

    localparam logic [FRAME_LOG2-1:0] LAST_OFFSET = {FRAME_LOG2{1'b1}};

    // Keeps the top OUT_W bits and flips the sign bit, turning two's complement into offset binary.
    function automatic logic [OUT_W-1:0] to_display(input logic [SAMPLE_W-1:0] sample);
        return {~sample[SAMPLE_W-1], sample[SAMPLE_W-2:SAMPLE_W-OUT_W]};
    endfunction

endpackage

// File: rtl/wave_capture_if.sv
// Sample stream in, display status in, ping-pong RAM write port and buffer select out.
interface wave_capture_if;
    import wave_capture_pkg::*;

    logic                new_sample_ready;
    logic [SAMPLE_W-1:0] new_sample_in;
    logic                wave_display_idle;
    logic [ADDR_W-1:0]   write_address;
    logic                write_enable;
    logic [OUT_W-1:0]    write_sample;
    logic                read_index;

    modport master (
        output new_sample_ready, new_sample_in, wave_display_idle,
        input  write_address, write_enable, write_sample, read_index
    );

    modport slave (
        input  new_sample_ready, new_sample_in, wave_display_idle,
        output write_address, write_enable, write_sample, read_index
    );

endinterface

// File: rtl/wave_capture.sv
// Captures one frame of audio into the half of a ping-pong RAM the display is
// not reading, starting on a rising zero crossing, then swaps halves when idle.
module wave_capture
    import wave_capture_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    wave_capture_if.slave   bus
);

    state_t                state_r;
    state_t                state_next_s;
    logic [FRAME_LOG2-1:0] offset_r;
    logic [FRAME_LOG2-1:0] offset_next_s;
    logic                  read_index_r;
    logic                  read_index_next_s;
    logic                  prev_msb_r;
    logic                  crossing_s;
    logic                  write_enable_s;

    // Next-state, offset, buffer swap and write strobe.
    always_comb begin
        state_next_s      = state_r;
        offset_next_s     = offset_r;
        read_index_next_s = read_index_r;
        write_enable_s    = 1'b0;
        crossing_s        = bus.new_sample_ready & prev_msb_r & ~bus.new_sample_in[SAMPLE_W-1];

        case (state_r)
            ST_ARMED: begin
                if (crossing_s) begin
                    write_enable_s = 1'b1;
                    offset_next_s  = {{(FRAME_LOG2-1){1'b0}}, 1'b1};
                    state_next_s   = ST_ACTIVE;
                end else begin
                    write_enable_s = 1'b0;
                end
            end
            ST_ACTIVE: begin
                if (bus.new_sample_ready) begin
                    write_enable_s = 1'b1;
                    if (offset_r == LAST_OFFSET) begin
                        offset_next_s = {FRAME_LOG2{1'b0}};
                        state_next_s  = ST_WAIT;
                    end else begin
                        offset_next_s = offset_r + {{(FRAME_LOG2-1){1'b0}}, 1'b1};
                    end
                end else begin
                    write_enable_s = 1'b0;
                end
            end
            ST_WAIT: begin
                if (bus.wave_display_idle) begin
                    read_index_next_s = ~read_index_r;
                    state_next_s      = ST_ARMED;
                end else begin
                    state_next_s = ST_WAIT;
                end
            end
            default: begin
                // Illegal encoding: abandon whatever was in progress and re-arm.
                state_next_s  = ST_ARMED;
                offset_next_s = {FRAME_LOG2{1'b0}};
            end
        endcase
    end

    // FSM, offset counter and buffer select.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r      <= ST_ARMED;
            offset_r     <= {FRAME_LOG2{1'b0}};
            read_index_r <= 1'b0;
        end else begin
            state_r      <= state_next_s;
            offset_r     <= offset_next_s;
            read_index_r <= read_index_next_s;
        end
    end

    // Sign of the previous sample, tracked in every state so arming sees fresh history.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev_msb_r <= 1'b0;
        end else if (bus.new_sample_ready) begin
            prev_msb_r <= bus.new_sample_in[SAMPLE_W-1];
        end else begin
            prev_msb_r <= prev_msb_r;
        end
    end

    // The RAM write port must act on the strobe cycle itself, so these stay combinational.
    assign bus.write_enable  = write_enable_s;
    assign bus.write_address = {~read_index_r, offset_r};
    assign bus.write_sample  = to_display(bus.new_sample_in);
    assign bus.read_index    = read_index_r;

endmodule

// File: tb/tb_wave_capture.sv
// Scoreboard bench for wave_capture: expected RAM writes are queued as samples
// are driven and checked by a monitor on the falling edge.
module tb_wave_capture;

    logic clk;
    logic reset;
    int   n_compared;
    int   n_mismatched;

    typedef struct packed {
        logic [8:0] addr;
        logic [7:0] data;
    } wr_t;

    wr_t exp_q[$];

    wave_capture_if bus ();

    wave_capture dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] disp(input logic [15:0] s);
        logic [7:0] r;
        r[7]   = ~s[15];
        r[6:0] = s[14:8];
        return r;
    endfunction

    // Every observed write must match the next queued expectation.
    always @(negedge clk) begin
        if (bus.write_enable === 1'b1) begin
            n_compared++;
            if (exp_q.size() == 0) begin
                n_mismatched++;
                $display("FAIL unexpected_write: got addr=%h data=%h, required no write", bus.write_address, bus.write_sample);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                if (bus.write_address !== e.addr || bus.write_sample !== e.data) begin
                    n_mismatched++;
                    $display("FAIL write: got addr=%h data=%h, required addr=%h data=%h",
                             bus.write_address, bus.write_sample, e.addr, e.data);
                end
            end
        end
    end

    task automatic strobe(input logic [15:0] s, input bit expect_wr, input logic [8:0] addr);
        wr_t e;
        @(posedge clk);
        #1;
        if (expect_wr) begin
            e.addr = addr;
            e.data = disp(s);
            exp_q.push_back(e);
        end
        bus.new_sample_in    = s;
        bus.new_sample_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.new_sample_ready = 1'b0;
    endtask

    task automatic check_bit(input string name, input logic got, input logic req);
        n_compared++;
        if (got !== req) begin
            n_mismatched++;
            $display("FAIL %s: got %b, required %b", name, got, req);
        end
    endtask

    task automatic check_drained(input string name);
        n_compared++;
        if (exp_q.size() != 0) begin
            n_mismatched++;
            $display("FAIL %s: got %0d pending writes, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic swap_and_check(input logic req_index);
        @(posedge clk);
        #1;
        bus.wave_display_idle = 1'b1;
        @(posedge clk);
        #1;
        bus.wave_display_idle = 1'b0;
        check_bit("swap_read_index", bus.read_index, req_index);
    endtask

    task automatic test_reset();
        reset                 = 1'b0;
        bus.new_sample_ready  = 1'b0;
        bus.new_sample_in     = 16'h0000;
        bus.wave_display_idle = 1'b0;
        #20;
        reset = 1'b1;
        @(negedge clk);
        check_bit("reset_read_index", bus.read_index, 1'b0);
        check_bit("reset_write_enable", bus.write_enable, 1'b0);
        check_bit("reset_addr_msb", bus.write_address[8], 1'b1);
    endtask

    task automatic test_first_write();
        strobe(16'hFFFF, 1'b0, 9'h000);
        strobe(16'h3FFF, 1'b1, 9'h100);
        check_drained("first_write");
    endtask

    task automatic test_full_frame();
        for (int i = 1; i < 256; i++) begin
            strobe(16'h3FFF, 1'b1, 9'h100 + 9'(i));
        end
        check_drained("full_frame");
        @(posedge clk);
        #1;
        bus.new_sample_in    = 16'h3FFF;
        bus.new_sample_ready = 1'b1;
        @(negedge clk);
        check_bit("wait_no_write", bus.write_enable, 1'b0);
        @(posedge clk);
        #1;
        bus.new_sample_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_bit("wait_holds_index", bus.read_index, 1'b0);
    endtask

    task automatic test_swap();
        logic [15:0] s;
        swap_and_check(1'b1);
        strobe(16'hFFFF, 1'b0, 9'h000);
        strobe(16'h3FFF, 1'b1, 9'h000);
        // Random samples inside a frame, including zero crossings that must not re-arm.
        for (int i = 1; i < 256; i++) begin
            s = 16'($urandom);
            strobe(s, 1'b1, 9'(i));
        end
        check_drained("second_frame");
        strobe(16'h0000, 1'b0, 9'h000);
        swap_and_check(1'b0);
    endtask

    task automatic test_arm_pattern();
        logic [15:0] s;
        bus.wave_display_idle = 1'b1;
        strobe(16'h3FFF, 1'b0, 9'h000);
        strobe(16'h3FFF, 1'b0, 9'h000);
        strobe(16'h8000, 1'b0, 9'h000);
        strobe(16'h0000, 1'b1, 9'h100);
        bus.wave_display_idle = 1'b0;
        check_bit("idle_outside_wait", bus.read_index, 1'b0);
        check_drained("arm_pattern");
        for (int i = 1; i < 256; i++) begin
            s = 16'($urandom);
            strobe(s, 1'b1, 9'h100 + 9'(i));
        end
        check_drained("third_frame");
        swap_and_check(1'b1);
    endtask

    task automatic test_reset_mid_frame();
        strobe(16'hFFFF, 1'b0, 9'h000);
        strobe(16'h3FFF, 1'b1, 9'h000);
        for (int i = 1; i < 100; i++) begin
            strobe(16'h1234, 1'b1, 9'(i));
        end
        check_drained("pre_reset");
        @(posedge clk);
        #1;
        bus.new_sample_in    = 16'h0000;
        bus.new_sample_ready = 1'b1;
        #1;
        reset = 1'b0;
        #1;
        check_bit("midreset_write_enable", bus.write_enable, 1'b0);
        check_bit("midreset_read_index", bus.read_index, 1'b0);
        @(posedge clk);
        #1;
        bus.new_sample_ready = 1'b0;
        reset = 1'b1;
        strobe(16'h0000, 1'b0, 9'h000);
        strobe(16'h4000, 1'b0, 9'h000);
        strobe(16'hC000, 1'b0, 9'h000);
        strobe(16'h0100, 1'b1, 9'h100);
        strobe(16'h7FFF, 1'b1, 9'h101);
        check_drained("post_reset");
    endtask

    initial begin
        n_compared   = 0;
        n_mismatched = 0;
        test_reset();
        test_first_write();
        test_full_frame();
        test_swap();
        test_arm_pattern();
        test_reset_mid_frame();
        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
